alarm_timer_p: RTL and testbench
================================

Name: alarm_timer_p

Overview:
Parametrised countdown timer for the alarm controller. It generalises the fixed 4-bit second timer with a configurable second length and countdown width, and adds pause, abort, restart-while-running and a live remaining-seconds readout. It sits beside the main alarm FSM. The FSM consumes expired and one_hz_enable, and the siren consumes half_hz_enable.

Parameters:
CLK_PER_SEC, 100000000, clock cycles per second; simulation benches use 10; minimum 2.
VALUE_W, 4, width of the countdown value in seconds; minimum 1.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, active-high
value  in  VALUE_W  countdown length in seconds, sampled only when a start is accepted
start_timer  in  1  load value and run; accepted in any state
pause  in  1  level; freezes prescaler and countdown while high in RUN
abort  in  1  return to IDLE without expiring
expired  out  1  single-cycle pulse when the countdown reaches 0
busy  out  1  high in RUN or PAUSE
remaining  out  VALUE_W  seconds left; 0 in IDLE
one_hz_enable  out  1  single-cycle pulse once per second
half_hz_enable  out  1  0.5 Hz 50 % square wave for the siren

Behaviour:
- Reset is asynchronous and active-high: state=IDLE, prescaler=0, remaining=0, expired=0, busy=0, one_hz_enable=0, half_hz_enable=0.
- Prescaler: width clog2(CLK_PER_SEC). It counts 0..CLK_PER_SEC-1 and wraps. It runs in IDLE and RUN and holds in PAUSE.
- tick = (prescaler == CLK_PER_SEC-1) and not frozen.
- one_hz_enable is registered and is high for the cycle after each tick edge.
- half_hz_enable toggles on every tick.
- States: IDLE, RUN, PAUSE.
- Per-cycle priority: abort > start_timer > pause > tick.
  - abort (any state): go to IDLE, remaining=0, no expired pulse.
  - start_timer (any state): prescaler=0, half_hz_enable=0, remaining=value.
    - value=0: stay or go to IDLE; expired pulses next cycle.
    - otherwise: go to RUN.
    - A coincident tick is discarded; no decrement.
  - RUN with pause=1: go to PAUSE (prescaler frozen from this cycle). PAUSE with pause=0: go to RUN.
  - RUN with tick and remaining>1: remaining decrements.
  - RUN with tick and remaining==1: remaining=0, go to IDLE, expired=1 for exactly one cycle.
- Latency: a start with value V sampled at edge 0 produces expired high in the cycle following edge V*CLK_PER_SEC, plus the total number of cycles spent in PAUSE.
- remaining is registered; it decrements on the tick edge.
- busy = (state != IDLE), registered with the state.
- Restart in RUN or PAUSE reloads remaining and restarts timing from that edge; the old countdown never expires.
- Reset asserted mid-operation: all outputs go to 0 immediately with no expired pulse. Counting resumes from IDLE after release.
- value=2^VALUE_W-1 must not wrap; arithmetic is unsigned decrement only.
- No combinational path from any input to any output.

Test Plan:
All scenarios use CLK_PER_SEC=10, VALUE_W=4, with start pulsed for one cycle at edge 0.
1. value=3 -> one_hz_enable after edges 10, 20, 30; remaining 3→2→1→0; half_hz_enable 0→1→0→1; expired high only in the cycle after edge 30; busy falls with it.
2. value=0 -> expired high in the cycle after edge 0, busy never high, no decrement.
3. value=2, pause high over edges 5..19 (15 cycles) -> no ticks while paused, remaining holds at 2, expired after edge 35.
4. value=5, then start with value=2 at edge 25 -> remaining=2 after edge 25, expired after edge 45 and never after edge 50.
5. value=4, abort at edge 12 -> busy=0 and remaining=0 after edge 12, expired never asserted; start at edge 12 together with abort also yields IDLE.
6. value=15, async reset asserted mid-cycle at cycle 17 -> all outputs 0 without waiting for a clock edge, no expired. A second run after reset release with value=15 expires after exactly 150 cycles.

Source files
------------

// File: rtl/alarm_timer_p.sv
// -----------------------------------------------------------------------------
// alarm_timer_p
// Parametrised countdown timer that sits beside the main alarm FSM.
// A free-running prescaler divides the clock down to one tick per second.
// The tick drives the one_hz_enable pulse and the half_hz_enable siren square
// wave. It also decrements the countdown while the timer runs.
//
// Parameters
//   CLK_PER_SEC : clock cycles per second (>= 2)
//   VALUE_W     : width of the countdown value in seconds (>= 1)
//
// Ports
//   clock          in   system clock
//   reset          in   asynchronous reset, active-high
//   value          in   countdown length in seconds, sampled on an accepted start
//   start_timer    in   load value and run (accepted in any state)
//   pause          in   level; freezes prescaler and countdown while busy
//   abort          in   return to IDLE without expiring
//   expired        out  one-cycle pulse when the countdown reaches 0
//   busy           out  high in RUN or PAUSE
//   remaining      out  seconds left, 0 in IDLE
//   one_hz_enable  out  one-cycle pulse per second
//   half_hz_enable out  0.5 Hz, 50 % square wave
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module alarm_timer_p #(
  parameter int CLK_PER_SEC = 100000000,
  parameter int VALUE_W     = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               start_timer,
  input  logic               pause,
  input  logic               abort,
  output logic               expired,
  output logic               busy,
  output logic [VALUE_W-1:0] remaining,
  output logic               one_hz_enable,
  output logic               half_hz_enable
);

  localparam int              PS_W    = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PS_W-1:0]    r_prescaler;
  logic [PS_W-1:0]    w_prescaler_nxt;
  logic [VALUE_W-1:0] r_remaining;
  logic [VALUE_W-1:0] w_remaining_nxt;
  logic               r_expired;
  logic               w_expired_nxt;
  logic               r_busy;
  logic               r_one_hz;
  logic               w_one_hz_nxt;
  logic               r_half_hz;
  logic               w_half_hz_nxt;
  logic               w_frozen;
  logic               w_tick;

  // Pause takes effect on the edge where it is first sampled, and it is
  // released on the edge where it is first seen low. As a result, PAUSE with
  // pause low already counts like RUN. This makes the latency grow by exactly
  // the number of cycles spent in PAUSE.
  assign w_frozen = (r_state != S_IDLE) && pause;
  assign w_tick   = (r_prescaler == PS_LAST) && !w_frozen;

  // Next-state, prescaler and countdown logic. The priority is
  // abort > start > pause > tick.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_expired_nxt   = 1'b0;
    w_one_hz_nxt    = w_tick;
    w_half_hz_nxt   = r_half_hz ^ w_tick;
    if (w_frozen) begin
      w_prescaler_nxt = r_prescaler;
    end else if (r_prescaler == PS_LAST) begin
      w_prescaler_nxt = {PS_W{1'b0}};
    end else begin
      w_prescaler_nxt = r_prescaler + PS_W'(1);
    end

    if (abort) begin
      // Timebase keeps running; only the countdown is dropped.
      w_state_nxt     = S_IDLE;
      w_remaining_nxt = {VALUE_W{1'b0}};
    end else if (start_timer) begin
      // A restart realigns the second boundary and discards any coincident tick.
      w_prescaler_nxt = {PS_W{1'b0}};
      w_half_hz_nxt   = 1'b0;
      w_one_hz_nxt    = 1'b0;
      w_remaining_nxt = value;
      if (value == {VALUE_W{1'b0}}) begin
        w_state_nxt   = S_IDLE;
        w_expired_nxt = 1'b1;
      end else begin
        w_state_nxt   = S_RUN;
      end
    end else begin
      case (r_state)
        S_RUN, S_PAUSE: begin
          if (pause) begin
            w_state_nxt = S_PAUSE;
          end else if (w_tick) begin
            if (r_remaining > VALUE_W'(1)) begin
              w_state_nxt     = S_RUN;
              w_remaining_nxt = r_remaining - VALUE_W'(1);
            end else begin
              w_state_nxt     = S_IDLE;
              w_remaining_nxt = {VALUE_W{1'b0}};
              w_expired_nxt   = 1'b1;
            end
          end else begin
            w_state_nxt = S_RUN;
          end
        end
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt     = S_IDLE;
          w_remaining_nxt = {VALUE_W{1'b0}};
        end
      endcase
    end
  end

  // State, timebase and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_prescaler <= {PS_W{1'b0}};
      r_remaining <= {VALUE_W{1'b0}};
      r_expired   <= 1'b0;
      r_busy      <= 1'b0;
      r_one_hz    <= 1'b0;
      r_half_hz   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prescaler <= w_prescaler_nxt;
      r_remaining <= w_remaining_nxt;
      r_expired   <= w_expired_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_one_hz    <= w_one_hz_nxt;
      r_half_hz   <= w_half_hz_nxt;
    end
  end

  assign expired        = r_expired;
  assign busy           = r_busy;
  assign remaining      = r_remaining;
  assign one_hz_enable  = r_one_hz;
  assign half_hz_enable = r_half_hz;

endmodule

// File: tb/tb_alarm_timer_p.sv
// -----------------------------------------------------------------------------
// tb_alarm_timer_p
// Bench for alarm_timer_p with CLK_PER_SEC=10 and VALUE_W=4.
// The reference model counts the unfrozen clock edges since the last start or
// reset. From that count it derives the second phase, the remaining seconds
// (V - cnt/C), the expiry point (cnt == V*C) and the siren level
// ((cnt/C) mod 2).
// -----------------------------------------------------------------------------
module tb_alarm_timer_p;
  localparam int C = 10;
  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] value;
  logic         start_timer;
  logic         pause;
  logic         abort;
  logic         expired;
  logic         busy;
  logic [W-1:0] remaining;
  logic         one_hz_enable;
  logic         half_hz_enable;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  int m_cnt;
  bit m_busy;
  int m_v;
  bit m_exp;
  bit m_one;

  alarm_timer_p #(.CLK_PER_SEC(C), .VALUE_W(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .value          (value),
    .start_timer    (start_timer),
    .pause          (pause),
    .abort          (abort),
    .expired        (expired),
    .busy           (busy),
    .remaining      (remaining),
    .one_hz_enable  (one_hz_enable),
    .half_hz_enable (half_hz_enable)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_busy = 1'b0;
    m_v    = 0;
    m_exp  = 1'b0;
    m_one  = 1'b0;
  endtask

  task automatic model_edge(input bit st, input int v, input bit pa, input bit ab);
    bit frozen;
    bit tk;
    frozen = m_busy && pa;
    tk     = !frozen && (((m_cnt + 1) % C) == 0);
    m_exp  = 1'b0;
    m_one  = 1'b0;
    if (ab) begin
      if (!frozen) m_cnt++;
      m_one  = tk;
      m_busy = 1'b0;
    end else if (st) begin
      m_cnt  = 0;
      m_v    = v;
      m_busy = (v != 0);
      m_exp  = (v == 0);
    end else begin
      if (!frozen) m_cnt++;
      m_one = tk;
      if (m_busy && !frozen && m_cnt == m_v * C) begin
        m_busy = 1'b0;
        m_exp  = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int rem;
    rem = m_busy ? (m_v - m_cnt / C) : 0;
    check_val({tag, ".expired"},   expired,        m_exp);
    check_val({tag, ".busy"},      busy,           m_busy);
    check_val({tag, ".remaining"}, remaining,      rem);
    check_val({tag, ".one_hz"},    one_hz_enable,  m_one);
    check_val({tag, ".half_hz"},   half_hz_enable, (m_cnt / C) % 2);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, ".expired"},   expired,        0);
    check_val({tag, ".busy"},      busy,           0);
    check_val({tag, ".remaining"}, remaining,      0);
    check_val({tag, ".one_hz"},    one_hz_enable,  0);
    check_val({tag, ".half_hz"},   half_hz_enable, 0);
  endtask

  // One clock: drive at the negedge, update the model on the posedge, compare at the next negedge.
  task automatic cycle(input string tag, input bit st, input int v, input bit pa, input bit ab);
    start_timer = st;
    value       = v[W-1:0];
    pause       = pa;
    abort       = ab;
    @(posedge clock);
    model_edge(st, v, pa, ab);
    @(negedge clock);
    check_all(tag);
  endtask

  // Start v0 at edge 0, with an optional restart, abort and pause window.
  // The task records the edge of the first expiry and the number of expiry pulses.
  task automatic scen(input string tag, input int v0, input int rs_k, input int rs_v,
                      input int ab_k, input bit ab_st, input int p_lo, input int p_hi,
                      input int n, input int want_first, input int want_cnt);
    int first;
    int cnt;
    bit st;
    bit pa;
    bit ab;
    int v;
    first = -1;
    cnt   = 0;
    cycle({tag, ".flush"}, 1'b0, 0, 1'b0, 1'b1);
    for (int k = 0; k <= n; k++) begin
      st = (k == 0) || (k == rs_k) || ((k == ab_k) && ab_st);
      v  = (k == rs_k) ? rs_v : v0;
      pa = (k >= p_lo) && (k <= p_hi);
      ab = (k == ab_k);
      cycle(tag, st, v, pa, ab);
      if (expired === 1'b1) begin
        if (first < 0) first = k;
        cnt++;
      end
    end
    check_val({tag, ".first_expiry"}, first, want_first);
    check_val({tag, ".expiry_count"}, cnt, want_cnt);
  endtask

  initial begin
    bit r_pa;
    bit r_st;
    bit r_ab;
    int r_v;
    reset       = 1'b1;
    value       = '0;
    start_timer = 1'b0;
    pause       = 1'b0;
    abort       = 1'b0;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    reset = 1'b0;

    scen("s1_v3",       3, -1, 0, -1, 1'b0, -1, -1,  40,  30, 1);
    scen("s2_v0",       0, -1, 0, -1, 1'b0, -1, -1,  15,   0, 1);
    scen("s3_pause",    2, -1, 0, -1, 1'b0,  5, 19,  45,  35, 1);
    scen("s4_restart",  5, 25, 2, -1, 1'b0, -1, -1,  60,  45, 1);
    scen("s5_abort",    4, -1, 0, 12, 1'b0, -1, -1,  50,  -1, 0);
    scen("s5_abort_st", 4, -1, 0, 12, 1'b1, -1, -1,  50,  -1, 0);

    // Assert reset mid-operation, between edges; the outputs must clear without a clock.
    cycle("s6_pre", 1'b0, 0, 1'b0, 1'b1);
    cycle("s6_pre", 1'b1, 15, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) cycle("s6_run", 1'b0, 0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_zero("s6_async");
    model_reset();
    @(posedge clock);
    @(negedge clock);
    check_zero("s6_hold");
    reset = 1'b0;
    scen("s6_after", 15, -1, 0, -1, 1'b0, -1, -1, 160, 150, 1);

    // random traffic against the model
    r_pa = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(19) == 0) r_pa = ~r_pa;
      r_st = ($urandom_range(39) == 0);
      r_ab = ($urandom_range(79) == 0);
      r_v  = ($urandom_range(1) == 0) ? int'($urandom_range(3)) : int'($urandom_range(15));
      cycle("rand", r_st, r_v, r_pa, r_ab);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
